regfile_arbiter: RTL and testbench

Two-client round-robin arbiter that shares the single-cycle CPU's 32x32 register file (two read ports, one write port, registered read data, active-low async clear) between two requesters, such as the core pipeline and a debug/DMA port. Each client issues complete transactions (a read of rs/rt, or a write of rd) over a valid/ready handshake. The arbiter serialises the transactions onto the regfile ports and returns read data with a one-cycle response strobe.

---
 rtl/regfile_arbiter.sv | 163 ++++++++++++++++
 tb/tb_regfile_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_arbiter : two-client round-robin arbiter onto a 2R1W register file
// Revision        : 1.0
// ----------------------------------------------------------------------------
module regfile_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // client 0
  input  logic              req_valid0_i,
  output logic              req_ready0_o,
  input  logic              req_write0_i,
  input  logic [ADDR_W-1:0] req_rs0_i,
  input  logic [ADDR_W-1:0] req_rt0_i,
  input  logic [ADDR_W-1:0] req_rd0_i,
  input  logic [DATA_W-1:0] req_wdata0_i,
  output logic              resp_valid0_o,
  output logic [DATA_W-1:0] resp_rs_data0_o,
  output logic [DATA_W-1:0] resp_rt_data0_o,
  // client 1
  input  logic              req_valid1_i,
  output logic              req_ready1_o,
  input  logic              req_write1_i,
  input  logic [ADDR_W-1:0] req_rs1_i,
  input  logic [ADDR_W-1:0] req_rt1_i,
  input  logic [ADDR_W-1:0] req_rd1_i,
  input  logic [DATA_W-1:0] req_wdata1_i,
  output logic              resp_valid1_o,
  output logic [DATA_W-1:0] resp_rs_data1_o,
  output logic [DATA_W-1:0] resp_rt_data1_o,
  // register file
  output logic [ADDR_W-1:0] rf_rs_o,
  output logic [ADDR_W-1:0] rf_rt_o,
  output logic [ADDR_W-1:0] rf_rd_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic              rf_write_o,
  input  logic [DATA_W-1:0] rf_rs_data_i,
  input  logic [DATA_W-1:0] rf_rt_data_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic                cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0]   cmd_rs_q, cmd_rs_d;
  logic [ADDR_W-1:0]   cmd_rt_q, cmd_rt_d;
  logic [ADDR_W-1:0]   cmd_rd_q, cmd_rd_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic                rf_write_q, rf_write_d;

  logic                arb_en;
  logic                winner;
  logic                accept;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_rs;
  logic [ADDR_W-1:0]   sel_rt;
  logic [ADDR_W-1:0]   sel_rd;
  logic [DATA_W-1:0]   sel_wdata;
  logic                resp_read;

  // On a tie the client that did not win last time is served.
  always_comb begin
    winner = 1'b0;
    if (req_valid0_i && req_valid1_i) begin
      winner = ~last_grant_q;
    end else if (req_valid1_i) begin
      winner = 1'b1;
    end
  end

  assign arb_en       = (state_q == IDLE) || (state_q == RESP);
  assign accept       = arb_en && (req_valid0_i || req_valid1_i);
  assign req_ready0_o = accept && !winner;
  assign req_ready1_o = accept &&  winner;

  assign sel_write = winner ? req_write1_i : req_write0_i;
  assign sel_rs    = winner ? req_rs1_i    : req_rs0_i;
  assign sel_rt    = winner ? req_rt1_i    : req_rt0_i;
  assign sel_rd    = winner ? req_rd1_i    : req_rd0_i;
  assign sel_wdata = winner ? req_wdata1_i : req_wdata0_i;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cmd_write_d  = cmd_write_q;
    cmd_rs_d     = cmd_rs_q;
    cmd_rt_d     = cmd_rt_q;
    cmd_rd_d     = cmd_rd_q;
    cmd_wdata_d  = cmd_wdata_q;
    rf_write_d   = 1'b0;
    unique case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          state_d      = ISSUE;
          last_grant_d = winner;
          owner_d      = winner;
          cmd_write_d  = sel_write;
          cmd_rs_d     = sel_rs;
          cmd_rt_d     = sel_rt;
          cmd_rd_d     = sel_rd;
          cmd_wdata_d  = sel_wdata;
          // r0 is hardwired zero, so its write strobe is never raised.
          rf_write_d   = sel_write && (sel_rd != '0);
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_rs_q     <= '0;
      cmd_rt_q     <= '0;
      cmd_rd_q     <= '0;
      cmd_wdata_q  <= '0;
      rf_write_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cmd_write_q  <= cmd_write_d;
      cmd_rs_q     <= cmd_rs_d;
      cmd_rt_q     <= cmd_rt_d;
      cmd_rd_q     <= cmd_rd_d;
      cmd_wdata_q  <= cmd_wdata_d;
      rf_write_q   <= rf_write_d;
    end
  end

  assign rf_rs_o    = cmd_rs_q;
  assign rf_rt_o    = cmd_rt_q;
  assign rf_rd_o    = cmd_rd_q;
  assign rf_wdata_o = cmd_wdata_q;
  assign rf_write_o = rf_write_q;

  // Regfile read data is valid in RESP, having been sampled at the end of ISSUE.
  assign resp_valid0_o   = (state_q == RESP) && !owner_q;
  assign resp_valid1_o   = (state_q == RESP) &&  owner_q;
  assign resp_read       = !cmd_write_q;
  assign resp_rs_data0_o = (resp_valid0_o && resp_read) ? rf_rs_data_i : '0;
  assign resp_rt_data0_o = (resp_valid0_o && resp_read) ? rf_rt_data_i : '0;
  assign resp_rs_data1_o = (resp_valid1_o && resp_read) ? rf_rs_data_i : '0;
  assign resp_rt_data1_o = (resp_valid1_o && resp_read) ? rf_rt_data_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_regfile_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_regfile_arbiter : directed bench for regfile_arbiter with a 32x32 regfile
// Revision           : 1.0
// ----------------------------------------------------------------------------
module tb_regfile_arbiter;

  logic        clk;
  logic        rst_n;
  logic        rf_clr_n;
  logic        v0, v1, w0, w1;
  logic [4:0]  rs0, rt0, rd0, rs1, rt1, rd1;
  logic [31:0] wd0, wd1;
  logic        rdy0, rdy1, rv0, rv1;
  logic [31:0] rsd0, rtd0, rsd1, rtd1;
  logic [4:0]  rf_rs, rf_rt, rf_rd;
  logic [31:0] rf_wdata;
  logic        rf_write;
  logic [31:0] rf_rs_data, rf_rt_data;
  logic [31:0] rf_mem [32];

  int n_vec = 0;
  int n_err = 0;

  regfile_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid0_i(v0), .req_ready0_o(rdy0), .req_write0_i(w0),
    .req_rs0_i(rs0), .req_rt0_i(rt0), .req_rd0_i(rd0), .req_wdata0_i(wd0),
    .resp_valid0_o(rv0), .resp_rs_data0_o(rsd0), .resp_rt_data0_o(rtd0),
    .req_valid1_i(v1), .req_ready1_o(rdy1), .req_write1_i(w1),
    .req_rs1_i(rs1), .req_rt1_i(rt1), .req_rd1_i(rd1), .req_wdata1_i(wd1),
    .resp_valid1_o(rv1), .resp_rs_data1_o(rsd1), .resp_rt_data1_o(rtd1),
    .rf_rs_o(rf_rs), .rf_rt_o(rf_rt), .rf_rd_o(rf_rd), .rf_wdata_o(rf_wdata),
    .rf_write_o(rf_write), .rf_rs_data_i(rf_rs_data), .rf_rt_data_i(rf_rt_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file with registered read ports and its own clear.
  always @(posedge clk or negedge rf_clr_n) begin
    if (!rf_clr_n) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h0;
      rf_rs_data <= 32'h0;
      rf_rt_data <= 32'h0;
    end else begin
      rf_rs_data <= rf_mem[rf_rs];
      rf_rt_data <= rf_mem[rf_rt];
      if (rf_write) rf_mem[rf_rd] <= rf_wdata;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    v0 = 0; v1 = 0; w0 = 0; w1 = 0;
    rs0 = 0; rt0 = 0; rd0 = 0; rs1 = 0; rt1 = 0; rd1 = 0;
    wd0 = 0; wd1 = 0;
  endtask

  task automatic arb_reset_pulse;
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 0; rf_clr_n = 0;
    @(negedge clk);
    n_vec++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin n_err++; $display("FAIL rst_ready got=%b%b exp=00", rdy0, rdy1); end
    n_vec++; if (rv0 !== 1'b0 || rv1 !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid got=%b%b exp=00", rv0, rv1); end
    n_vec++; if (rf_write !== 1'b0 || rf_rs !== 5'd0 || rf_rt !== 5'd0 || rf_rd !== 5'd0) begin n_err++; $display("FAIL rst_rf_ctrl got=%b/%0d/%0d/%0d exp=0/0/0/0", rf_write, rf_rs, rf_rt, rf_rd); end
    n_vec++; if (rf_wdata !== 32'h0) begin n_err++; $display("FAIL rst_rf_wdata got=%h exp=0", rf_wdata); end
    n_vec++; if ({rsd0, rtd0, rsd1, rtd1} !== 128'h0) begin n_err++; $display("FAIL rst_resp_data got=%h exp=0", {rsd0, rtd0, rsd1, rtd1}); end
    step();
    rst_n = 1; rf_clr_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++; if ({rdy0, rdy1, rv0, rv1, rf_write} !== 5'b0) begin n_err++; $display("FAIL idle_outputs cyc=%0d got=%b exp=00000", k, {rdy0, rdy1, rv0, rv1, rf_write}); end
      step();
    end
  endtask

  task automatic test_write_read;
    v0 = 1; w0 = 1; rd0 = 5'd3; wd0 = 32'hDEADBEEF;
    @(negedge clk);
    n_vec++; if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin n_err++; $display("FAIL wr_ready_c0 got=%b%b exp=10", rdy0, rdy1); end
    step();
    idle_inputs();
    @(negedge clk);
    n_vec++; if (rf_write !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_issue_c1 got=%b/%0d/%h exp=1/3/deadbeef", rf_write, rf_rd, rf_wdata); end
    n_vec++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL wr_noready_c1 got=%b exp=0", rdy0); end
    step();
    v0 = 1; w0 = 0; rs0 = 5'd3; rt0 = 5'd0;
    @(negedge clk);
    n_vec++; if (rv0 !== 1'b1 || rsd0 !== 32'h0 || rtd0 !== 32'h0) begin n_err++; $display("FAIL wr_resp_c2 got=%b/%h/%h exp=1/0/0", rv0, rsd0, rtd0); end
    n_vec++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL rd_ready_c2 got=%b exp=1", rdy0); end
    step();
    idle_inputs();
    @(negedge clk);
    n_vec++; if (rf_write !== 1'b0 || rf_rs !== 5'd3 || rf_rt !== 5'd0 || rv0 !== 1'b0) begin n_err++; $display("FAIL rd_issue_c3 got=%b/%0d/%0d/%b exp=0/3/0/0", rf_write, rf_rs, rf_rt, rv0); end
    step();
    @(negedge clk);
    n_vec++; if (rv0 !== 1'b1 || rsd0 !== 32'hDEADBEEF || rtd0 !== 32'h0) begin n_err++; $display("FAIL rd_resp_c4 got=%b/%h/%h exp=1/deadbeef/0", rv0, rsd0, rtd0); end
    n_vec++; if (rv1 !== 1'b0) begin n_err++; $display("FAIL rd_resp1_c4 got=%b exp=0", rv1); end
    step();
    @(negedge clk);
    n_vec++; if (rv0 !== 1'b0) begin n_err++; $display("FAIL rd_resp_once_c5 got=%b exp=0", rv0); end
    step();
  endtask

  task automatic test_round_robin;
    logic e_r0, e_r1, e_v0, e_v1;
    arb_reset_pulse();
    v0 = 1; w0 = 0; rs0 = 5'd3; rt0 = 5'd0;
    v1 = 1; w1 = 0; rs1 = 5'd0; rt1 = 5'd3;
    for (int k = 0; k < 9; k++) begin
      if (k == 8) begin v0 = 0; v1 = 0; end
      e_r0 = (k % 4 == 0) && (k < 8);
      e_r1 = (k % 4 == 2);
      e_v0 = (k % 4 == 2);
      e_v1 = (k % 4 == 0) && (k >= 4);
      @(negedge clk);
      n_vec++; if (rdy0 !== e_r0 || rdy1 !== e_r1) begin n_err++; $display("FAIL rr_ready cyc=%0d got=%b%b exp=%b%b", k, rdy0, rdy1, e_r0, e_r1); end
      n_vec++; if (rv0 !== e_v0 || rv1 !== e_v1) begin n_err++; $display("FAIL rr_resp_valid cyc=%0d got=%b%b exp=%b%b", k, rv0, rv1, e_v0, e_v1); end
      if (e_v0) begin
        n_vec++; if (rsd0 !== 32'hDEADBEEF || rtd0 !== 32'h0 || rsd1 !== 32'h0 || rtd1 !== 32'h0) begin n_err++; $display("FAIL rr_data0 cyc=%0d got=%h/%h/%h/%h exp=deadbeef/0/0/0", k, rsd0, rtd0, rsd1, rtd1); end
      end
      if (e_v1) begin
        n_vec++; if (rsd1 !== 32'h0 || rtd1 !== 32'hDEADBEEF || rsd0 !== 32'h0 || rtd0 !== 32'h0) begin n_err++; $display("FAIL rr_data1 cyc=%0d got=%h/%h/%h/%h exp=0/deadbeef/0/0", k, rsd1, rtd1, rsd0, rtd0); end
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_write_r0;
    v1 = 1; w1 = 1; rd1 = 5'd0; wd1 = 32'h1234;
    @(negedge clk);
    n_vec++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL r0w_ready got=%b exp=1", rdy1); end
    step();
    idle_inputs();
    @(negedge clk);
    n_vec++; if (rf_write !== 1'b0 || rf_rd !== 5'd0) begin n_err++; $display("FAIL r0w_no_write got=%b/%0d exp=0/0", rf_write, rf_rd); end
    step();
    v1 = 1; w1 = 0; rs1 = 5'd0; rt1 = 5'd0;
    @(negedge clk);
    n_vec++; if (rv1 !== 1'b1 || rv0 !== 1'b0 || rsd1 !== 32'h0) begin n_err++; $display("FAIL r0w_resp got=%b%b/%h exp=10/0", rv1, rv0, rsd1); end
    n_vec++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL r0r_ready_in_resp got=%b exp=1", rdy1); end
    step();
    idle_inputs();
    step();
    @(negedge clk);
    n_vec++; if (rv1 !== 1'b1 || rsd1 !== 32'h0 || rtd1 !== 32'h0) begin n_err++; $display("FAIL r0r_data got=%b/%h/%h exp=1/0/0", rv1, rsd1, rtd1); end
    step();
  endtask

  task automatic test_cross_order;
    arb_reset_pulse();
    v0 = 1; w0 = 1; rd0 = 5'd7; wd0 = 32'h55;
    v1 = 1; w1 = 0; rs1 = 5'd7; rt1 = 5'd3;
    @(negedge clk);
    n_vec++; if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin n_err++; $display("FAIL xo_tie_c0 got=%b%b exp=10", rdy0, rdy1); end
    step();
    v0 = 0; w0 = 0; rd0 = 0; wd0 = 0;
    @(negedge clk);
    n_vec++; if (rdy1 !== 1'b0 || rf_write !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h55) begin n_err++; $display("FAIL xo_issue_c1 got=%b/%b/%0d/%h exp=0/1/7/55", rdy1, rf_write, rf_rd, rf_wdata); end
    step();
    @(negedge clk);
    n_vec++; if (rv0 !== 1'b1 || rdy1 !== 1'b1) begin n_err++; $display("FAIL xo_resp_c2 got=%b%b exp=11", rv0, rdy1); end
    step();
    idle_inputs();
    @(negedge clk);
    n_vec++; if (rf_rs !== 5'd7 || rf_rt !== 5'd3 || rf_write !== 1'b0) begin n_err++; $display("FAIL xo_issue_c3 got=%0d/%0d/%b exp=7/3/0", rf_rs, rf_rt, rf_write); end
    step();
    @(negedge clk);
    n_vec++; if (rv1 !== 1'b1 || rsd1 !== 32'h55 || rtd1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL xo_data_c4 got=%b/%h/%h exp=1/55/deadbeef", rv1, rsd1, rtd1); end
    step();
  endtask

  task automatic test_stall;
    v0 = 1; w0 = 0; rs0 = 5'd3; rt0 = 5'd7;
    @(negedge clk);
    n_vec++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL st_ready0_c0 got=%b exp=1", rdy0); end
    step();
    v0 = 0;
    v1 = 1; w1 = 1; rs1 = 5'd1; rt1 = 5'd2; rd1 = 5'd9; wd1 = 32'hCAFEF00D;
    @(negedge clk);
    n_vec++; if (rdy1 !== 1'b0 || rdy0 !== 1'b0) begin n_err++; $display("FAIL st_wait_issue got=%b%b exp=00", rdy0, rdy1); end
    step();
    @(negedge clk);
    n_vec++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL st_ready1_resp got=%b exp=1", rdy1); end
    n_vec++; if (rv0 !== 1'b1 || rsd0 !== 32'hDEADBEEF || rtd0 !== 32'h55) begin n_err++; $display("FAIL st_resp0 got=%b/%h/%h exp=1/deadbeef/55", rv0, rsd0, rtd0); end
    step();
    idle_inputs();
    @(negedge clk);
    n_vec++; if (rf_write !== 1'b1 || rf_rd !== 5'd9 || rf_rs !== 5'd1 || rf_rt !== 5'd2 || rf_wdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL st_latched got=%b/%0d/%0d/%0d/%h exp=1/9/1/2/cafef00d", rf_write, rf_rd, rf_rs, rf_rt, rf_wdata); end
    step();
    @(negedge clk);
    n_vec++; if (rv1 !== 1'b1 || rsd1 !== 32'h0 || rtd1 !== 32'h0) begin n_err++; $display("FAIL st_resp1 got=%b/%h/%h exp=1/0/0", rv1, rsd1, rtd1); end
    step();
  endtask

  task automatic test_reset_in_issue;
    v0 = 1; w0 = 1; rd0 = 5'd10; wd0 = 32'h77;
    @(negedge clk);
    n_vec++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL ri_ready got=%b exp=1", rdy0); end
    step();
    idle_inputs();
    @(negedge clk);
    n_vec++; if (rf_write !== 1'b1) begin n_err++; $display("FAIL ri_issue got=%b exp=1", rf_write); end
    #1 rst_n = 0;
    #1;
    n_vec++; if (rf_write !== 1'b0 || rf_rd !== 5'd0) begin n_err++; $display("FAIL ri_async_clear got=%b/%0d exp=0/0", rf_write, rf_rd); end
    step();
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++; if (rv0 !== 1'b0 || rv1 !== 1'b0 || rf_write !== 1'b0) begin n_err++; $display("FAIL ri_no_resp cyc=%0d got=%b%b%b exp=000", k, rv0, rv1, rf_write); end
      step();
    end
    n_vec++; if (rf_mem[10] !== 32'h0) begin n_err++; $display("FAIL ri_no_commit got=%h exp=0", rf_mem[10]); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst_n = 0;
    rf_clr_n = 0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_write_r0();
    test_cross_order();
    test_stall();
    test_reset_in_issue();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
